// File: rtl/switch_conditioner_pkg.sv
// switch_pkg
//   Shared types and constants for the slide-switch conditioning path.
//   deb_state_t             : per-channel debouncer state encoding
//   DEFAULT_DEBOUNCE_CYCLES : 20 ms worth of samples at a 50 MHz clock
package switch_pkg;

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    TO_HIGH = 2'd1,
    HIGH    = 2'd2,
    TO_LOW  = 2'd3
  } deb_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

endpackage : switch_pkg

// File: rtl/switch_conditioner_debounce.sv
// debounce_channel
//   One switch channel: two-flop synchronizer, consecutive-sample counter,
//   debounce FSM and registered rise/fall pulse outputs.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   LOW     | debounced level is 0, synchronized input agrees
//   TO_HIGH | input reads 1, counting consecutive 1 samples toward a rise
//   HIGH    | debounced level is 1, synchronized input agrees
//   TO_LOW  | input reads 0, counting consecutive 0 samples toward a fall
//
// Ports
//   clock    : system clock
//   reset    : synchronous, active-high
//   sw_raw   : asynchronous raw switch pin
//   sw_level : debounced level (registered)
//   sw_rise  : one-cycle pulse, coincident with the first cycle of level=1
//   sw_fall  : one-cycle pulse, coincident with the first cycle of level=0
module debounce_channel
  import switch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic sw_raw,
  output logic sw_level,
  output logic sw_rise,
  output logic sw_fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  deb_state_t    state;
  deb_state_t    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          level_nxt;
  logic          rise_nxt;
  logic          fall_nxt;

  // Synchronizer: only s2 is allowed to reach the debounce logic.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  // The entering sample already counts as 1, so the terminal compare is
  // DEBOUNCE_CYCLES-1; cnt therefore never wraps.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = sw_level;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      LOW: begin
        cnt_nxt   = '0;
        level_nxt = 1'b0;
        if (s2) begin
          state_nxt = TO_HIGH;
          cnt_nxt   = CNT_ONE;
        end
      end
      TO_HIGH: begin
        if (!s2) begin
          state_nxt = LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HIGH;
          level_nxt = 1'b1;
          rise_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HIGH: begin
        cnt_nxt   = '0;
        level_nxt = 1'b1;
        if (!s2) begin
          state_nxt = TO_LOW;
          cnt_nxt   = CNT_ONE;
        end
      end
      TO_LOW: begin
        if (s2) begin
          state_nxt = HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = LOW;
          level_nxt = 1'b0;
          fall_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = LOW;
        cnt_nxt   = '0;
        level_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= LOW;
      cnt      <= '0;
      sw_level <= 1'b0;
      sw_rise  <= 1'b0;
      sw_fall  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      sw_level <= level_nxt;
      sw_rise  <= rise_nxt;
      sw_fall  <= fall_nxt;
    end
  end

endmodule : debounce_channel

// File: rtl/switch_conditioner.sv
// switch_conditioner
//   Conditions N_SW slide switches for the downstream control FSMs.
//   Channels are fully independent copies of debounce_channel.
//
// Ports
//   clock    : system clock (CLOCK_50)
//   reset    : synchronous, active-high
//   sw_raw   : raw asynchronous switch pins
//   sw_level : debounced levels
//   sw_rise  : per-channel one-cycle pulse on debounced 0->1
//   sw_fall  : per-channel one-cycle pulse on debounced 1->0
module switch_conditioner
  import switch_pkg::*;
#(
  parameter int N_SW            = 8,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_level,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall
);

  for (genvar i = 0; i < N_SW; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .sw_raw  (sw_raw[i]),
      .sw_level(sw_level[i]),
      .sw_rise (sw_rise[i]),
      .sw_fall (sw_fall[i])
    );
  end

endmodule : switch_conditioner

// File: tb/tb_switch_conditioner.sv
// Testbench for switch_conditioner with DEBOUNCE_CYCLES=4, N_SW=8.
// Stimulus pushes expected pulse events (cycle, rise, fall, level) into a
// queue; the monitor pops one whenever the DUT shows any pulse.
module tb_switch_conditioner;

  localparam int N = 8;
  localparam int D = 4;

  logic         clock  = 1'b0;
  logic         reset  = 1'b1;
  logic [N-1:0] sw_raw = '0;
  logic [N-1:0] sw_level;
  logic [N-1:0] sw_rise;
  logic [N-1:0] sw_fall;

  switch_conditioner #(.N_SW(N), .DEBOUNCE_CYCLES(D)) dut (
    .clock   (clock),
    .reset   (reset),
    .sw_raw  (sw_raw),
    .sw_level(sw_level),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall)
  );

  always #5 clock = ~clock;

  typedef struct {
    int           at;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] level;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic rst_edge = 1'b1;
  logic [N-1:0] prev_level = '0;

  // cyc = number of posedges so far; at a negedge it names the edge just taken.
  always @(posedge clock) begin
    cyc      = cyc + 1;
    rst_edge = reset;
  end

  // Monitor
  always @(negedge clock) begin
    exp_t e;
    if ((sw_rise | sw_fall) != '0) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse cyc=%0d rise=%h fall=%h level=%h", cyc, sw_rise, sw_fall, sw_level);
      end else begin
        e = q.pop_front();
        if (cyc != e.at || sw_rise !== e.rise || sw_fall !== e.fall || sw_level !== e.level) begin
          n_bad++;
          $display("FAIL pulse_event got cyc=%0d rise=%h fall=%h level=%h want cyc=%0d rise=%h fall=%h level=%h",
                   cyc, sw_rise, sw_fall, sw_level, e.at, e.rise, e.fall, e.level);
        end
      end
    end else if (!rst_edge) begin
      n_cmp++;
      if (sw_level !== prev_level) begin
        n_bad++;
        $display("FAIL level_without_pulse cyc=%0d level=%h want=%h", cyc, sw_level, prev_level);
      end
    end
    if (q.size() > 0 && cyc > q[0].at) begin
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missed_pulse cyc=%0d rise=%h fall=%h want at=%0d rise=%h fall=%h",
               cyc, sw_rise, sw_fall, e.at, e.rise, e.fall);
    end
    prev_level = sw_level;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic expect_ev(input int at, input logic [N-1:0] r, input logic [N-1:0] f,
                           input logic [N-1:0] l);
    exp_t e;
    e.at = at; e.rise = r; e.fall = f; e.level = l;
    q.push_back(e);
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if ((sw_level | sw_rise | sw_fall) !== '0) begin
      n_bad++;
      $display("FAIL %s level=%h rise=%h fall=%h want all 0", name, sw_level, sw_rise, sw_fall);
    end
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (q.size() > 0 && guard < 50) begin
      tick(1);
      guard++;
    end
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain pending=%0d want 0", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    int k;
    // Reset, then idle with switches low
    tick(3);
    check_zero("reset_state");
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check_zero("idle_low");
    end

    // Clean rise: sampled at edge k+1, level after edge k+D+2
    k = cyc;
    sw_raw = 8'h01;
    expect_ev(k + D + 2, 8'h01, 8'h00, 8'h01);
    tick(10);
    drain("clean_rise");

    // Fall from debounced high
    k = cyc;
    sw_raw = 8'h00;
    expect_ev(k + D + 2, 8'h00, 8'h01, 8'h00);
    tick(10);
    drain("fall");

    // Bounce: 3 high, 1 low, then held high -> rise 4 edges later than clean
    k = cyc;
    sw_raw = 8'h01;
    tick(3);
    sw_raw = 8'h00;
    tick(1);
    sw_raw = 8'h01;
    expect_ev(k + 10, 8'h01, 8'h00, 8'h01);
    tick(3);
    n_cmp++;
    if (sw_level !== 8'h00) begin
      n_bad++;
      $display("FAIL bounce_no_change level=%h want 00", sw_level);
    end
    tick(9);
    drain("bounce_rise");
    k = cyc;
    sw_raw = 8'h00;
    expect_ev(k + D + 2, 8'h00, 8'h01, 8'h00);
    tick(10);
    drain("bounce_fall");

    // Independence: channels 0 and 6 two cycles apart
    k = cyc;
    sw_raw = 8'h01;
    expect_ev(k + 6, 8'h01, 8'h00, 8'h01);
    expect_ev(k + 8, 8'h40, 8'h00, 8'h41);
    tick(2);
    sw_raw = 8'h41;
    tick(10);
    drain("indep_rise");
    k = cyc;
    sw_raw = 8'h40;
    expect_ev(k + 6, 8'h00, 8'h01, 8'h40);
    expect_ev(k + 8, 8'h00, 8'h40, 8'h00);
    tick(2);
    sw_raw = 8'h00;
    tick(10);
    drain("indep_fall");

    // Reset while channel 0 is in TO_HIGH with cnt=2
    k = cyc;
    sw_raw = 8'h01;
    tick(4);
    reset = 1'b1;
    tick(1);
    check_zero("reset_mid_count");
    reset = 1'b0;
    expect_ev(k + 11, 8'h01, 8'h00, 8'h01);
    tick(12);
    drain("after_reset_rise");
    k = cyc;
    sw_raw = 8'h00;
    expect_ev(k + D + 2, 8'h00, 8'h01, 8'h00);
    tick(10);
    drain("after_reset_fall");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_switch_conditioner
